pq_ctrl: RTL and testbench

//  Prefetch-queue controller for the pine16 CPU front end. Fetches 16-bit code words over the shared

---
 rtl/pq_if.sv | 31 +++
 rtl/pq_ctrl.sv | 141 ++++++++++++++
 tb/tb_pq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_if.sv
// Decoder and memory-bus signal bundle for the pine16 prefetch-queue controller.
// master = pq_ctrl, slave = decoder plus bus arbiter/memory side.
interface pq_if #(
    parameter int AW = 16
);
    // Decoder: rqi_p is a level request. The controller answers with a one-cycle aki_n
    // and cmd_n valid in that cycle, and never acks on two consecutive cycles.
    // Bus: bus_req stays high with bus_adr stable until bus_gnt. bus_rdy later marks
    // the single outstanding read word on bus_din.
    logic          rqi_p;
    logic          rql_p;
    logic          aki_n;
    logic [31:0]   cmd_n;
    logic          flush_p;
    logic [AW-1:0] flush_adr;
    logic          bus_req;
    logic [AW-1:0] bus_adr;
    logic          bus_gnt;
    logic          bus_rdy;
    logic [15:0]   bus_din;

    modport master (
        input  rqi_p, rql_p, flush_p, flush_adr, bus_gnt, bus_rdy, bus_din,
        output aki_n, cmd_n, bus_req, bus_adr
    );

    modport slave (
        output rqi_p, rql_p, flush_p, flush_adr, bus_gnt, bus_rdy, bus_din,
        input  aki_n, cmd_n, bus_req, bus_adr
    );
endinterface

// File: rtl/pq_ctrl.sv
// Prefetch queue: fetches 16-bit code words into a circular queue and serves 32-bit command windows.
// Optional PQ_STALL_CNT_EN adds a saturating stall_cnt output.
module pq_ctrl #(
    parameter int DEPTH_W = 3,
    parameter int AW      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pq_if.master       pq,
    output logic [1:0] fsm_state
`ifdef PQ_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] DEPTH_C = (DEPTH_W+1)'(1) << DEPTH_W;

    state_t           state;
    logic [AW-1:0]    fptr;
    logic [AW-1:0]    adr_r;
    logic             req_r;
    logic             aki_r;
    logic [31:0]      cmd_r;
    logic [DEPTH_W:0] head;
    logic [DEPTH_W:0] tail;
    logic [DEPTH_W:0] count;
    logic [DEPTH_W:0] need;
    logic [DEPTH_W-1:0] h0;
    logic [DEPTH_W-1:0] h1;
    logic [AW-1:0]    flush_base;
    logic             do_ack;
    logic             do_wr;
    logic [15:0]      mem [DEPTH];

    assign count      = tail - head;
    assign need       = pq.rql_p ? (DEPTH_W+1)'(2) : (DEPTH_W+1)'(1);
    assign h0         = head[DEPTH_W-1:0];
    assign h1         = head[DEPTH_W-1:0] + (DEPTH_W)'(1);
    assign flush_base = pq.flush_adr & ~(AW)'(1);

    // The !aki_r term keeps acks at least one cycle apart.
    assign do_ack = pq.rqi_p && !pq.flush_p && !aki_r && (count >= need);
    assign do_wr  = (state == WAIT) && pq.bus_rdy && !pq.flush_p;

    assign pq.aki_n    = aki_r;
    assign pq.cmd_n    = cmd_r;
    assign pq.bus_req  = req_r;
    assign pq.bus_adr  = adr_r;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[tail[DEPTH_W-1:0]] <= pq.bus_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            aki_r <= 1'b0;
            cmd_r <= '0;
        end else begin
            aki_r <= do_ack;
            if (do_ack) begin
                cmd_r <= {mem[h0], (pq.rql_p ? mem[h1] : 16'h0000)};
            end
            if (pq.flush_p) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (do_ack) head <= head + need;
                if (do_wr)  tail <= tail + (DEPTH_W+1)'(1);
            end
        end
    end

    // Only one fetch is ever outstanding and IDLE has none in flight, so checking
    // count alone in IDLE reserves room for the returning word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fptr  <= '0;
            adr_r <= '0;
            req_r <= 1'b0;
        end else if (pq.flush_p) begin
            fptr  <= flush_base;
            req_r <= 1'b0;
            case (state)
                WAIT, DROP: state <= pq.bus_rdy ? IDLE : DROP;
                default:    state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count < DEPTH_C) begin
                        state <= REQ;
                        req_r <= 1'b1;
                        adr_r <= fptr;
                    end
                end
                REQ: begin
                    if (pq.bus_gnt) begin
                        state <= WAIT;
                        req_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (pq.bus_rdy) begin
                        state <= IDLE;
                        fptr  <= fptr + (AW)'(2);
                    end
                end
                DROP: begin
                    if (pq.bus_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (pq.rqi_p && !aki_r && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pq_ctrl.sv
// Bench for pq_ctrl: directed bus/decoder scenarios, then randomized traffic against
// an address-stream model (memory returns word = address).
module tb_pq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;
    int         n_vec;
    int         n_err;

    pq_if #(.AW(16)) bus ();

`ifdef PQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
    int          stall_model;
`endif

    pq_ctrl #(.DEPTH_W(3), .AW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pq        (bus.master),
        .fsm_state (fsm_state)
`ifdef PQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference stream: the decoder must see consecutive word addresses starting at
    // the last flush target.
    logic [15:0] exp_q[$];
    logic [15:0] next_adr;

    // Random bus responder, active only in the random phase.
    logic        auto_bus;
    logic        rsp_pend;
    logic [15:0] rsp_adr;
    int          rsp_wait;

    initial begin
        rsp_pend = 1'b0;
        rsp_adr  = '0;
        rsp_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_bus) begin
                bus.bus_gnt = 1'b0;
                bus.bus_rdy = 1'b0;
                if (rsp_pend) begin
                    if (rsp_wait == 0) begin
                        bus.bus_rdy = 1'b1;
                        bus.bus_din = rsp_adr;
                        rsp_pend    = 1'b0;
                    end else begin
                        rsp_wait--;
                    end
                end else if (bus.bus_req && ($urandom_range(0, 2) != 0)) begin
                    bus.bus_gnt = 1'b1;
                    rsp_pend    = 1'b1;
                    rsp_adr     = bus.bus_adr;
                    rsp_wait    = $urandom_range(0, 2);
                end
            end
        end
    end

`ifdef PQ_STALL_CNT_EN
    always @(posedge clk) begin
        if (!rst_n) stall_model = 0;
        else if (bus.rqi_p && !bus.aki_n && stall_model < 65535) stall_model++;
    end
`endif

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int i;
        i = 0;
        while (!bus.bus_req && i < 50) begin
            tick();
            i++;
        end
        check({tag, "_req"}, 32'(bus.bus_req), 32'd1);
    endtask

    task automatic fetch_one(input logic [15:0] exp_adr, input int rdy_lat, input string tag);
        logic [15:0] a;
        wait_req(tag);
        check({tag, "_adr"}, 32'(bus.bus_adr), 32'(exp_adr));
        a = bus.bus_adr;
        bus.bus_gnt = 1'b1;
        tick();
        bus.bus_gnt = 1'b0;
        repeat (rdy_lat) tick();
        bus.bus_rdy = 1'b1;
        bus.bus_din = a;
        tick();
        bus.bus_rdy = 1'b0;
    endtask

    task automatic req_ack(input logic rql, input logic [31:0] exp, input string tag);
        int lat;
        bus.rqi_p = 1'b1;
        bus.rql_p = rql;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.aki_n && lat < 50);
        bus.rqi_p = 1'b0;
        check({tag, "_ack"}, 32'(bus.aki_n), 32'd1);
        check({tag, "_cmd"}, bus.cmd_n, exp);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        tick();
    endtask

    initial begin
        logic        prev_rqi, prev_rql, prev_flush, prev_aki;
        logic [15:0] prev_fadr;
        logic [31:0] exp_cmd;
        int          acks;

        n_vec = 0;
        n_err = 0;
        auto_bus = 1'b0;
        bus.rqi_p = 1'b0;
        bus.rql_p = 1'b0;
        bus.flush_p = 1'b0;
        bus.flush_adr = '0;
        bus.bus_gnt = 1'b0;
        bus.bus_rdy = 1'b0;
        bus.bus_din = '0;
        rst_n = 1'b0;
        repeat (3) tick();

        check("rst_aki", 32'(bus.aki_n), 32'd0);
        check("rst_cmd", bus.cmd_n, 32'd0);
        check("rst_req", 32'(bus.bus_req), 32'd0);
        check("rst_adr", 32'(bus.bus_adr), 32'd0);
        check("rst_fsm", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;

        // Fill the queue from 0x0000 and confirm fetching stops when full.
        for (int i = 0; i < 8; i++) fetch_one(16'(2 * i), i % 3, "fill");
        repeat (3) tick();
        check("full_noreq", 32'(bus.bus_req), 32'd0);
        check("full_idle", 32'(fsm_state), 32'd0);

        req_ack(1'b1, 32'h0000_0002, "full_ack");
        fetch_one(16'h0010, 0, "refetch");
        fetch_one(16'h0012, 1, "refetch2");
        req_ack(1'b1, 32'h0004_0006, "drain0");
        req_ack(1'b1, 32'h0008_000A, "drain1");
        req_ack(1'b1, 32'h000C_000E, "drain2");
        req_ack(1'b1, 32'h0010_0012, "drain3");

        // Single word present: rql_p=0 acks at once, rql_p=1 waits for a second word.
        bus.flush_p = 1'b1;
        bus.flush_adr = 16'h1234;
        tick();
        bus.flush_p = 1'b0;
        check("flush_req_drop", 32'(bus.bus_req), 32'd0);
        fetch_one(16'h1234, 0, "one_a");
        req_ack(1'b0, 32'h1234_0000, "one_ack");
        fetch_one(16'h1236, 0, "one_b");
        bus.rqi_p = 1'b1;
        bus.rql_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("one_hold", 32'(bus.aki_n), 32'd0);
        end
        fetch_one(16'h1238, 1, "one_c");
        check("one_wait", 32'(bus.aki_n), 32'd0);
        tick();
        bus.rqi_p = 1'b0;
        check("two_ack", 32'(bus.aki_n), 32'd1);
        check("two_cmd", bus.cmd_n, 32'h1236_1238);
        tick();

        // Flush during WAIT, re-flush while dropping, then the stale word returns.
        wait_req("drop");
        bus.bus_gnt = 1'b1;
        tick();
        bus.bus_gnt = 1'b0;
        bus.flush_p = 1'b1;
        bus.flush_adr = 16'h3000;
        tick();
        check("drop_fsm", 32'(fsm_state), 32'd3);
        check("drop_req", 32'(bus.bus_req), 32'd0);
        bus.flush_adr = 16'h4000;
        tick();
        bus.flush_p = 1'b0;
        check("drop_refl", 32'(fsm_state), 32'd3);
        bus.bus_rdy = 1'b1;
        bus.bus_din = 16'hDEAD;
        tick();
        bus.bus_rdy = 1'b0;
        check("drop_done", 32'(fsm_state), 32'd0);
        fetch_one(16'h4000, 0, "fl_a");
        fetch_one(16'h4002, 2, "fl_b");
        req_ack(1'b1, 32'h4000_4002, "fl_ack");

        // Flush and bus_rdy in the same WAIT cycle: word discarded, no DROP.
        wait_req("flrdy");
        bus.bus_gnt = 1'b1;
        tick();
        bus.bus_gnt = 1'b0;
        bus.flush_p = 1'b1;
        bus.flush_adr = 16'h5000;
        bus.bus_rdy = 1'b1;
        bus.bus_din = 16'hBEEF;
        tick();
        bus.flush_p = 1'b0;
        bus.bus_rdy = 1'b0;
        check("flrdy_fsm", 32'(fsm_state), 32'd0);
        fetch_one(16'h5000, 0, "flrdy_a");
        req_ack(1'b0, 32'h5000_0000, "flrdy_ack");

        // Fetch pointer wrap; bit0 of flush_adr ignored.
        bus.flush_p = 1'b1;
        bus.flush_adr = 16'hFFFF;
        tick();
        bus.flush_p = 1'b0;
        fetch_one(16'hFFFE, 0, "wrap_a");
        fetch_one(16'h0000, 0, "wrap_b");
        req_ack(1'b1, 32'hFFFE_0000, "wrap_ack");

        // Write and ack on the same edge at count=2.
        fetch_one(16'h0002, 0, "sim_a");
        fetch_one(16'h0004, 0, "sim_b");
        wait_req("sim_c");
        check("sim_c_adr", 32'(bus.bus_adr), 32'h0006);
        bus.bus_gnt = 1'b1;
        tick();
        bus.bus_gnt = 1'b0;
        bus.rqi_p = 1'b1;
        bus.rql_p = 1'b1;
        bus.bus_rdy = 1'b1;
        bus.bus_din = 16'h0006;
        tick();
        bus.rqi_p = 1'b0;
        bus.bus_rdy = 1'b0;
        check("sim_ack", 32'(bus.aki_n), 32'd1);
        check("sim_cmd", bus.cmd_n, 32'h0002_0004);
        tick();
        req_ack(1'b0, 32'h0006_0000, "sim_head");
        bus.rqi_p = 1'b1;
        bus.rql_p = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sim_empty", 32'(bus.aki_n), 32'd0);
        end
        bus.rqi_p = 1'b0;

        // Randomized traffic against the address-stream model.
        auto_bus = 1'b1;
        prev_rqi = 1'b0;
        prev_rql = 1'b0;
        prev_flush = 1'b0;
        prev_aki = 1'b0;
        prev_fadr = '0;
        next_adr = '0;
        acks = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (bus.aki_n) begin
                acks++;
                check("rnd_legal", {29'd0, prev_rqi, prev_flush, prev_aki}, 32'h4);
                while (exp_q.size() < 2) begin
                    exp_q.push_back(next_adr);
                    next_adr = next_adr + 16'd2;
                end
                exp_cmd = {exp_q[0], (prev_rql ? exp_q[1] : 16'h0000)};
                void'(exp_q.pop_front());
                if (prev_rql) void'(exp_q.pop_front());
                check("rnd_cmd", bus.cmd_n, exp_cmd);
            end
            prev_aki = bus.aki_n;
            if (prev_flush) begin
                exp_q.delete();
                next_adr = prev_fadr & 16'hFFFE;
            end
            bus.rqi_p = ($urandom_range(0, 9) < 6);
            bus.rql_p = 1'($urandom_range(0, 1));
            bus.flush_p = (k == 0) || ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0) bus.flush_adr = 16'hFFF0 + 16'($urandom_range(0, 15));
            else bus.flush_adr = 16'($urandom);
            if (k == 0) bus.flush_adr = 16'h8000;
            prev_rqi = bus.rqi_p;
            prev_rql = bus.rql_p;
            prev_flush = bus.flush_p;
            prev_fadr = bus.flush_adr;
        end
        bus.rqi_p = 1'b0;
        bus.flush_p = 1'b0;
        repeat (4) tick();
        check("rnd_live", 32'(acks > 100), 32'd1);

`ifdef PQ_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stall_model));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
